// File: rtl/vtu_pkg.sv
// Shared types and helpers for the vertex transform unit: fixed-point type,
// FSM state encoding, the fixed-point 1.0 constant and a signed saturator.
package vtu_pkg;

   localparam int VTU_DATA_W = 16;
   localparam int VTU_FRAC   = 8;

   typedef logic signed [VTU_DATA_W-1:0] fx_t;

   localparam fx_t FX_ONE = fx_t'(32'sd1 <<< VTU_FRAC);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DIV_X = 3'd2,
      ST_DIV_Y = 3'd3,
      ST_DONE  = 3'd4
   } vtu_state_e;

   // Clamp a signed value into the range of a signed w-bit number.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 32'd1));
      if (v > hi) begin
         sat = hi;
      end else if (v < lo) begin
         sat = lo;
      end else begin
         sat = v;
      end
   endfunction

endpackage

// File: rtl/vtu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// produced in the start cycle, so a DIVD_W-bit quotient takes exactly DIVD_W
// cycles; 'done' and 'quotient_next' are valid together in the final cycle.
module vtu_divider
   import vtu_pkg::*;
#(
   parameter int DIVD_W = 24,
   parameter int DIVS_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIVD_W-1:0] dividend,
   input  logic [DIVS_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DIVD_W-1:0] quotient_next
);

   localparam int CW = $clog2(DIVD_W + 1);

   logic              busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DIVS_W-1:0] rem_q, rem_d;
   logic [DIVS_W-1:0] dsr_q, dsr_d;
   logic [DIVD_W-1:0] dvd_q, dvd_d;
   logic [DIVD_W-1:0] quo_q, quo_d;

   logic              active_s;
   logic [CW-1:0]     cnt_in_s;
   logic [DIVS_W-1:0] rem_in_s, dsr_in_s, rem_nx_s;
   logic [DIVD_W-1:0] dvd_in_s, quo_in_s, quo_nx_s;
   logic [DIVS_W:0]   trial_s;
   logic              bit_s;
   logic              done_s;

   // One restoring step: start loads fresh operands, otherwise continue from state.
   always_comb begin
      active_s = start | busy_q;
      if (start) begin
         cnt_in_s = {CW{1'b0}};
         rem_in_s = {DIVS_W{1'b0}};
         dvd_in_s = dividend;
         quo_in_s = {DIVD_W{1'b0}};
         dsr_in_s = divisor;
      end else begin
         cnt_in_s = cnt_q;
         rem_in_s = rem_q;
         dvd_in_s = dvd_q;
         quo_in_s = quo_q;
         dsr_in_s = dsr_q;
      end
      trial_s = {rem_in_s, dvd_in_s[DIVD_W-1]};
      if (trial_s >= {1'b0, dsr_in_s}) begin
         bit_s    = 1'b1;
         rem_nx_s = DIVS_W'(trial_s - {1'b0, dsr_in_s});
      end else begin
         bit_s    = 1'b0;
         rem_nx_s = trial_s[DIVS_W-1:0];
      end
      quo_nx_s = {quo_in_s[DIVD_W-2:0], bit_s};
      done_s   = active_s && (cnt_in_s == CW'(DIVD_W - 1));

      if (active_s) begin
         busy_d = ~done_s;
         cnt_d  = cnt_in_s + CW'(1);
         rem_d  = rem_nx_s;
         dvd_d  = {dvd_in_s[DIVD_W-2:0], 1'b0};
         quo_d  = quo_nx_s;
         dsr_d  = dsr_in_s;
      end else begin
         busy_d = 1'b0;
         cnt_d  = cnt_q;
         rem_d  = rem_q;
         dvd_d  = dvd_q;
         quo_d  = quo_q;
         dsr_d  = dsr_q;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= {CW{1'b0}};
         rem_q  <= {DIVS_W{1'b0}};
         dsr_q  <= {DIVS_W{1'b0}};
         dvd_q  <= {DIVD_W{1'b0}};
         quo_q  <= {DIVD_W{1'b0}};
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         dvd_q  <= dvd_d;
         quo_q  <= quo_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_s;
   assign quotient_next = quo_nx_s;

endmodule

// File: rtl/vertex_transform_unit.sv
// Multi-cycle world-to-screen transform of a NUM_VERT vertex batch: one view
// matrix row per cycle (4 multipliers), then perspective divide of x and y
// by w on a shared restoring divider. Results are staged and published
// together one cycle after DONE entry. Optional viewport offset/flip is
// enabled by defining VTU_VIEWPORT_EN.
module vertex_transform_unit
   import vtu_pkg::*;
#(
   parameter int DATA_W   = VTU_DATA_W,
   parameter int FRAC     = VTU_FRAC,
   parameter int NUM_VERT = 4,
   parameter int SCREEN_W = 10
`ifdef VTU_VIEWPORT_EN
   , parameter int VP_X_OFF = 32'sd320
   , parameter int VP_Y_OFF = 32'sd240
`endif
) (
   input  logic                                         Clk,
   input  logic                                         Reset_n,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [NUM_VERT-1:0][2:0][DATA_W-1:0]         vertices,
   input  logic [15:0][DATA_W-1:0]                      vm,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [NUM_VERT-1:0][1:0][SCREEN_W-1:0]       ss_vertices,
   output logic [NUM_VERT-1:0]                          clipped
);

   localparam int QW = DATA_W + FRAC;
   localparam int SW = 2 * DATA_W + 2;
   localparam int VW = (NUM_VERT > 1) ? $clog2(NUM_VERT) : 1;

   vtu_state_e                               state_q, state_d;
   logic [VW-1:0]                            vidx_q, vidx_d;
   logic [1:0]                               row_q, row_d;
   logic [NUM_VERT-1:0][2:0][DATA_W-1:0]     vert_q, vert_d;
   logic [15:0][DATA_W-1:0]                  vm_q, vm_d;
   logic signed [DATA_W-1:0]                 cs_x_q, cs_x_d, cs_y_q, cs_y_d, cs_w_q, cs_w_d;
   logic [NUM_VERT-1:0][1:0][SCREEN_W-1:0]   stg_ss_q, stg_ss_d, ss_q, ss_d;
   logic [NUM_VERT-1:0]                      stg_clip_q, stg_clip_d, clip_q, clip_d;
   logic                                     out_valid_q, out_valid_d, in_ready_q, in_ready_d;

   logic signed [DATA_W-1:0]   ws_s [4];
   logic signed [2*DATA_W-1:0] prod_s [4];
   logic signed [SW-1:0]       sum_s;
   logic signed [DATA_W-1:0]   row_val_s;

   logic signed [DATA_W-1:0]   div_a_s;
   logic                       a_neg_s;
   logic [DATA_W-1:0]          a_mag_s;
   logic                       div_start_s, div_busy_s, div_done_s;
   logic [QW-1:0]              div_q_next_s;
   logic signed [63:0]         q_mag_s, q_sgn_s, scr_pre_s;
   logic [SCREEN_W-1:0]        scr_s;
   logic                       clip_now_s;

   vtu_divider #(.DIVD_W(QW), .DIVS_W(DATA_W)) u_div (
      .clk           (Clk),
      .rst_n         (Reset_n),
      .start         (div_start_s),
      .dividend      ({a_mag_s, {FRAC{1'b0}}}),
      .divisor       ($unsigned(cs_w_q)),
      .busy          (div_busy_s),
      .done          (div_done_s),
      .quotient_next (div_q_next_s)
   );

   // Current matrix row times homogeneous vertex, rescaled and saturated.
   always_comb begin
      ws_s[0] = vert_q[vidx_q][0];
      ws_s[1] = vert_q[vidx_q][1];
      ws_s[2] = vert_q[vidx_q][2];
      ws_s[3] = DATA_W'(64'sd1 <<< FRAC);
      sum_s   = {SW{1'b0}};
      for (int c = 0; c < 4; c++) begin
         prod_s[c] = $signed(vm_q[{row_q, 2'(c)}]) * ws_s[c];
         sum_s     = sum_s + SW'(prod_s[c]);
      end
      row_val_s = DATA_W'(sat(64'(sum_s >>> FRAC), DATA_W));
   end

   // Divider operands and signed, optionally offset, screen coordinate.
   always_comb begin
      if (state_q == ST_DIV_Y) begin
         div_a_s = cs_y_q;
      end else begin
         div_a_s = cs_x_q;
      end
      a_neg_s = div_a_s[DATA_W-1];
      if (a_neg_s) begin
         a_mag_s = DATA_W'(~div_a_s) + DATA_W'(1'b1);
      end else begin
         a_mag_s = div_a_s;
      end
      div_start_s = ((state_q == ST_DIV_X) || (state_q == ST_DIV_Y)) && !div_busy_s;
      clip_now_s  = cs_w_q[DATA_W-1] || (cs_w_q == {DATA_W{1'b0}});
      q_mag_s     = 64'(div_q_next_s);
      if (a_neg_s) begin
         q_sgn_s = -q_mag_s;
      end else begin
         q_sgn_s = q_mag_s;
      end
`ifdef VTU_VIEWPORT_EN
      if (state_q == ST_DIV_Y) begin
         scr_pre_s = 64'(VP_Y_OFF) - q_sgn_s;
      end else begin
         scr_pre_s = q_sgn_s + 64'(VP_X_OFF);
      end
`else
      scr_pre_s = q_sgn_s;
`endif
      if (clip_now_s) begin
         scr_s = {SCREEN_W{1'b0}};
      end else begin
         scr_s = SCREEN_W'(sat(scr_pre_s, SCREEN_W));
      end
   end

   // Sequencing: accept, per-vertex MUL/DIV_X/DIV_Y, then publish and handshake.
   always_comb begin
      state_d     = state_q;
      vidx_d      = vidx_q;
      row_d       = row_q;
      vert_d      = vert_q;
      vm_d        = vm_q;
      cs_x_d      = cs_x_q;
      cs_y_d      = cs_y_q;
      cs_w_d      = cs_w_q;
      stg_ss_d    = stg_ss_q;
      stg_clip_d  = stg_clip_q;
      ss_d        = ss_q;
      clip_d      = clip_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               vert_d  = vertices;
               vm_d    = vm;
               vidx_d  = {VW{1'b0}};
               row_d   = 2'd0;
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            case (row_q)
               2'd0:    cs_x_d = row_val_s;
               2'd1:    cs_y_d = row_val_s;
               2'd3:    cs_w_d = row_val_s;
               default: cs_x_d = cs_x_q;  // z row is not needed downstream
            endcase
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
               state_d = ST_DIV_X;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV_X: begin
            if (div_done_s) begin
               stg_ss_d[vidx_q][0] = scr_s;
               state_d             = ST_DIV_Y;
            end else begin
               state_d = ST_DIV_X;
            end
         end
         ST_DIV_Y: begin
            if (div_done_s) begin
               stg_ss_d[vidx_q][1] = scr_s;
               stg_clip_d[vidx_q]  = clip_now_s;
               if (vidx_q == VW'(NUM_VERT - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  vidx_d  = vidx_q + VW'(1);
                  row_d   = 2'd0;
                  state_d = ST_MUL;
               end
            end else begin
               state_d = ST_DIV_Y;
            end
         end
         ST_DONE: begin
            if (!out_valid_q) begin
               ss_d        = stg_ss_q;
               clip_d      = stg_clip_q;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   // All control and datapath registers of the unit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         vidx_q      <= {VW{1'b0}};
         row_q       <= 2'd0;
         vert_q      <= {(NUM_VERT*3*DATA_W){1'b0}};
         vm_q        <= {(16*DATA_W){1'b0}};
         cs_x_q      <= {DATA_W{1'b0}};
         cs_y_q      <= {DATA_W{1'b0}};
         cs_w_q      <= {DATA_W{1'b0}};
         stg_ss_q    <= {(NUM_VERT*2*SCREEN_W){1'b0}};
         stg_clip_q  <= {NUM_VERT{1'b0}};
         ss_q        <= {(NUM_VERT*2*SCREEN_W){1'b0}};
         clip_q      <= {NUM_VERT{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         vidx_q      <= vidx_d;
         row_q       <= row_d;
         vert_q      <= vert_d;
         vm_q        <= vm_d;
         cs_x_q      <= cs_x_d;
         cs_y_q      <= cs_y_d;
         cs_w_q      <= cs_w_d;
         stg_ss_q    <= stg_ss_d;
         stg_clip_q  <= stg_clip_d;
         ss_q        <= ss_d;
         clip_q      <= clip_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign ss_vertices = ss_q;
   assign clipped     = clip_q;

endmodule

// File: tb/tb_vertex_transform_unit.sv
// Self-checking bench for vertex_transform_unit: integer reference model of
// the transform, a per-cycle compare process while out_valid is high, and
// directed batches covering saturation, truncation, clipping, back-pressure,
// back-to-back accept and mid-batch reset.
module tb_vertex_transform_unit;
   import vtu_pkg::*;

   localparam int NV  = 4;
   localparam int DW  = 16;
   localparam int SCW = 10;
   localparam int LAT = 209;

   logic                          Clk;
   logic                          Reset_n;
   logic                          in_valid;
   logic                          in_ready;
   logic [NV-1:0][2:0][DW-1:0]    vertices;
   logic [15:0][DW-1:0]           vm;
   logic                          out_valid;
   logic                          out_ready;
   logic [NV-1:0][1:0][SCW-1:0]   ss_vertices;
   logic [NV-1:0]                 clipped;

   vertex_transform_unit dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .vertices    (vertices),
      .vm          (vm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ss_vertices (ss_vertices),
      .clipped     (clipped)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     cur_v [NV][3];
   int     cur_vm [16];
   longint exp_ss [NV][2];
   bit     exp_clip [NV];
   bit     exp_vld = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint satw(input longint v, input int w);
      longint lim;
      lim = longint'(1) << (w - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
   endfunction

   // Reference: camera space by plain matrix arithmetic, then |a|*256/w with sign.
   task automatic model_batch();
      longint ws [4];
      longint cs [4];
      longint acc, q, s;
      for (int i = 0; i < NV; i++) begin
         ws[0] = cur_v[i][0];
         ws[1] = cur_v[i][1];
         ws[2] = cur_v[i][2];
         ws[3] = longint'(FX_ONE);
         for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) acc += longint'(cur_vm[4*r+c]) * ws[c];
            cs[r] = satw(acc >>> 8, DW);
         end
         exp_clip[i] = (cs[3] <= 0);
         for (int k = 0; k < 2; k++) begin
            if (exp_clip[i]) begin
               exp_ss[i][k] = 0;
            end else begin
               q = ((cs[k] < 0 ? -cs[k] : cs[k]) * 256) / cs[3];
               s = (cs[k] < 0) ? -q : q;
`ifdef VTU_VIEWPORT_EN
               s = (k == 0) ? s + 320 : 240 - s;
`endif
               exp_ss[i][k] = satw(s, SCW);
            end
         end
      end
      exp_vld = 1'b1;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NV; i++)
         for (int j = 0; j < 3; j++) vertices[i][j] = DW'(cur_v[i][j]);
      for (int k = 0; k < 16; k++) vm[k] = DW'(cur_vm[k]);
   endtask

   task automatic set_vm(input int diag, input int w0, input int w1, input int w2, input int w3);
      for (int k = 0; k < 16; k++) cur_vm[k] = 0;
      cur_vm[0]  = diag;
      cur_vm[5]  = diag;
      cur_vm[10] = diag;
      cur_vm[12] = w0;
      cur_vm[13] = w1;
      cur_vm[14] = w2;
      cur_vm[15] = w3;
   endtask

   task automatic set_v(input int i, input int x, input int y, input int z);
      cur_v[i][0] = x;
      cur_v[i][1] = y;
      cur_v[i][2] = z;
   endtask

   // Compare DUT against the model on every cycle the batch is presented.
   always @(negedge Clk) begin
      if (Reset_n && out_valid && exp_vld) begin
         for (int i = 0; i < NV; i++)
            for (int j = 0; j < 2; j++)
               check($sformatf("ss[%0d][%0d]", i, j),
                     longint'($signed(ss_vertices[i][j])), exp_ss[i][j]);
         for (int i = 0; i < NV; i++)
            check($sformatf("clipped[%0d]", i), longint'(clipped[i]), longint'(exp_clip[i]));
      end
   end

   // One full batch: accept, latency, hold in DONE, handshake.
   task automatic run_batch(input int hold, input bit want_now);
      int waitc;
      int lat;
      model_batch();
      apply_inputs();
      in_valid = 1'b1;
      waitc = 0;
      while (!in_ready && waitc < 400) begin
         @(posedge Clk); #1;
         waitc++;
      end
      if (want_now) check("accept_wait", waitc, 0);
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge Clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < NV; i++)
         for (int j = 0; j < 3; j++) vertices[i][j] = DW'($urandom);
      for (int k = 0; k < 16; k++) vm[k] = DW'($urandom);
      check("in_ready_busy", longint'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 1000) begin
         @(posedge Clk); #1;
         lat++;
      end
      check("latency", lat, LAT);
      for (int h = 0; h < hold; h++) begin
         @(posedge Clk); #1;
         check("hold_valid", longint'(out_valid), 1);
         check("hold_in_ready", longint'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      check("post_hs_valid", longint'(out_valid), 0);
      check("post_hs_in_ready", longint'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vertices  = '0;
      vm        = '0;
      #12;
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_ss_zero", longint'(ss_vertices == '0), 1);
      check("rst_clipped", longint'(clipped), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      // Identity matrix: saturation of y, negative x, clamp of large values.
      set_vm(256, 0, 0, 0, 256);
      set_v(0, 256, 512, 0);
      set_v(1, -256, 128, 0);
      set_v(2, 1000, -3000, 5);
      set_v(3, -100, 50, 0);
      model_batch();
`ifndef VTU_VIEWPORT_EN
      check("pin_t1_x0", exp_ss[0][0], 256);
      check("pin_t1_y0", exp_ss[0][1], 511);
      check("pin_t1_y2", exp_ss[2][1], -512);
`endif
      run_batch(3, 1'b0);

      // w = 2.0 with truncation toward zero, held 50 cycles in DONE.
      set_vm(256, 0, 0, 0, 512);
      set_v(0, 256, -256, 0);
      set_v(1, -255, 3, 0);
      set_v(2, 32767, -32768, 0);
      set_v(3, 0, 0, 0);
      model_batch();
`ifndef VTU_VIEWPORT_EN
      check("pin_t2_x0", exp_ss[0][0], 128);
      check("pin_t2_y0", exp_ss[0][1], -128);
      check("pin_t2_x1", exp_ss[1][0], -127);
`endif
      run_batch(50, 1'b0);

      // Back-to-back: new batch must be taken in the IDLE cycle after handshake.
      set_vm(256, 0, 0, 0, 0);
      set_v(0, 256, 512, 0);
      set_v(1, -256, 128, 0);
      set_v(2, 1000, -3000, 5);
      set_v(3, -100, 50, 0);
      model_batch();
      check("pin_t3_clip", longint'({exp_clip[3], exp_clip[2], exp_clip[1], exp_clip[0]}), 15);
      run_batch(0, 1'b1);

      // Mid-batch reset discards everything.
      set_vm(256, 0, 0, 0, 512);
      apply_inputs();
      in_valid = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      repeat (100) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #2;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_in_ready", longint'(in_ready), 1);
      check("midrst_ss_zero", longint'(ss_vertices == '0), 1);
      check("midrst_clipped", longint'(clipped), 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      // w taken from z: positive, negative, zero, positive -> clip 0110.
      set_vm(256, 0, 0, 256, 0);
      set_v(0, 256, 512, 256);
      set_v(1, 300, 300, -256);
      set_v(2, 300, 300, 0);
      set_v(3, 100, -100, 512);
      model_batch();
      check("pin_t5_clip", longint'({exp_clip[3], exp_clip[2], exp_clip[1], exp_clip[0]}), 6);
`ifndef VTU_VIEWPORT_EN
      check("pin_t5_x3", exp_ss[3][0], 50);
`endif
      run_batch(2, 1'b1);

      repeat (3) @(posedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
